// File: rtl/jogo_unidade_controle.sv
// Moore control unit for the memory game: waits for a player move, registers
// and compares each key, ends on mismatch, success or timeout (JOGO_TIMEOUT_EN).
module jogo_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TMR_W          = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fimC,
    input  logic       chavesIgualMemoria,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Encodings double as the debug code shown on the 7-segment display.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;
    logic    tmr_fim;

    // Elaboration-time sanity checks on the timeout configuration.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((TIMEOUT_CYCLES - 1) >= (1 << TMR_W)) begin : g_bad_tmr_w
        $error("TMR_W too narrow for TIMEOUT_CYCLES-1");
    end

`ifdef JOGO_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    assign tmr_fim = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Timer counts only while staying in espera; any entry restarts at 0.
    always_comb begin
        tmr_d = '0;
        if (estado_q == ESPERA && estado_d == ESPERA) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Timer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign tmr_fim = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; a move beats the timeout on the terminal cycle.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL: begin
                estado_d = iniciar ? PREPARACAO : INICIAL;
            end
            PREPARACAO: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (tmr_fim) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!chavesIgualMemoria) begin
                    estado_d = FIM_ERRO;
                end else if (fimC) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                estado_d = ESPERA;
            end
            FIM_ACERTO: begin
                estado_d = iniciar ? PREPARACAO : FIM_ACERTO;
            end
            FIM_TIMEOUT: begin
                estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            end
            FIM_ERRO: begin
                estado_d = iniciar ? PREPARACAO : FIM_ERRO;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // Moore output decode; illegal encodings show F and drive nothing else.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = 4'hF;
        case (estado_q)
            INICIAL: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h0;
            end
            PREPARACAO: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = 4'h1;
            end
            ESPERA: begin
                db_estado = 4'h2;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = 4'h4;
            end
            COMPARACAO: begin
                db_estado = 4'h5;
            end
            PROXIMO: begin
                contaC    = 1'b1;
                db_estado = 4'h6;
            end
            FIM_ACERTO: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = 4'hA;
            end
            FIM_TIMEOUT: begin
                pronto    = 1'b1;
`ifdef JOGO_TIMEOUT_EN
                timeout   = 1'b1;
`endif
                db_estado = 4'hD;
            end
            FIM_ERRO: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = 4'hE;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

endmodule
